// File: rtl/rams_byte_we_param.sv
// Single-port block RAM with byte-lane write enables, selectable read-during-write behaviour,
// optional output register and an optional post-reset zero-fill sequencer.
module rams_byte_we_param #(
  parameter int NB_COL     = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int SIZE       = 512,
  parameter int WRITE_MODE = 0,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NB_COL-1:0]           we,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic [NB_COL*COL_WIDTH-1:0] di,
  output logic [NB_COL*COL_WIDTH-1:0] dout,
  output logic                        do_valid,
  output logic                        init_busy
);
  localparam int W  = NB_COL * COL_WIDTH;
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_q;
  logic [IW-1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_CLEAR != 0) ? CLEAR : RUN;
      cnt_q   <= '0;
    end else if (state_q == CLEAR) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == IW'(SIZE - 1)) state_q <= RUN;
    end
  end

  assign init_busy = (state_q == CLEAR);

  logic              clearing;
  logic              access;
  logic              in_range;
  logic              no_change_hold;
  logic              rd_valid_d;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     wr_idx;
  logic [W-1:0]      wr_word;
  logic [NB_COL-1:0] wr_lane;

  assign clearing       = (state_q == CLEAR) && !rst;
  assign access         = (state_q == RUN) && en && !rst;
  assign in_range       = {1'b0, addr} < (ADDR_WIDTH + 1)'(SIZE);
  assign idx            = addr[IW-1:0];
  assign wr_idx         = clearing ? cnt_q : idx;
  assign wr_word        = clearing ? '0 : di;
  assign no_change_hold = (WRITE_MODE == 2) && (|we);
  assign rd_valid_d     = access && !no_change_hold;

  // The sequencer owns the single write port while clearing; user writes need an in-range address.
  for (genvar gi = 0; gi < NB_COL; gi++) begin : g_lane_we
    assign wr_lane[gi] = clearing || (access && in_range && we[gi]);
  end

  logic [W-1:0] mem [SIZE];
  logic [W-1:0] rd_q;
  logic         rd_valid_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB_COL; i++) begin
      if (wr_lane[i]) mem[wr_idx][i*COL_WIDTH +: COL_WIDTH] <= wr_word[i*COL_WIDTH +: COL_WIDTH];
    end
  end

  // Array reads return the pre-edge word; write-first substitutes the freshly written lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      if (rd_valid_d) begin
        for (int i = 0; i < NB_COL; i++) begin
          if (WRITE_MODE == 1 && wr_lane[i])
            rd_q[i*COL_WIDTH +: COL_WIDTH] <= di[i*COL_WIDTH +: COL_WIDTH];
          else if (in_range)
            rd_q[i*COL_WIDTH +: COL_WIDTH] <= mem[idx][i*COL_WIDTH +: COL_WIDTH];
          else
            rd_q[i*COL_WIDTH +: COL_WIDTH] <= '0;
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [W-1:0] do_q;
    logic         do_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        do_q       <= '0;
        do_valid_q <= 1'b0;
      end else begin
        do_valid_q <= rd_valid_q;
        if (rd_valid_q) do_q <= rd_q;
      end
    end

    assign dout     = do_q;
    assign do_valid = do_valid_q;
  end else begin : g_out_direct
    assign dout     = rd_q;
    assign do_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_rams_byte_we_param.sv
// Drives one stimulus stream into every WRITE_MODE x OUT_REG variant (plus a no-clear variant)
// and scores each against a word-level memory model.
module tb_rams_byte_we_param;
  localparam int NI   = 7;
  localparam int NC   = 6;
  localparam int SIZE = 512;
  localparam int AW   = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [3:0]    we  = '0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   di  = '0;

  logic [31:0] dout_w [NI];
  logic        dv_w   [NI];
  logic        busy_w [NI];

  typedef struct {
    logic [31:0] d;
    int          cyc;
  } exp_t;

  exp_t        sbq [NC][$];
  exp_t        mon_e;
  logic [31:0] last_do [NC];
  logic [31:0] mem_m [SIZE];
  int          cyc = 0;
  int          clr_left = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_on = 1'b0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    rams_byte_we_param #(
      .NB_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(AW), .SIZE(SIZE),
      .WRITE_MODE(gi % 3), .OUT_REG((gi >= 3) ? 1 : 0), .INIT_CLEAR((gi < NC) ? 1 : 0)
    ) dut (
      .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .di(di),
      .dout(dout_w[gi]), .do_valid(dv_w[gi]), .init_busy(busy_w[gi])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc=%0d got=%h exp=%h", name, inst, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int k = 0; k < NI; k++)
        chk("init_busy", k, 32'(busy_w[k]), (k < NC && clr_left > 0) ? 32'd1 : 32'd0);
      for (int k = 0; k < NC; k++) begin
        if (dv_w[k]) begin
          if (sbq[k].size() == 0) begin
            chk("unexpected_valid", k, 32'd1, 32'd0);
          end else begin
            mon_e = sbq[k].pop_front();
            chk("do_cycle", k, cyc, mon_e.cyc);
            chk("do_data", k, dout_w[k], mon_e.d);
            last_do[k] = mon_e.d;
          end
        end else begin
          chk("do_hold", k, dout_w[k], last_do[k]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst) clr_left = SIZE;
    else if (clr_left > 0) clr_left--;
    #1;
  endtask

  task automatic access(input logic e, input logic [3:0] w, input logic [AW-1:0] a, input logic [31:0] d);
    logic [31:0] old_w;
    logic [31:0] new_w;
    logic        inr;
    exp_t        x;
    en = e; we = w; addr = a; di = d;
    if (e && !rst && clr_left == 0) begin
      inr   = int'(a) < SIZE;
      old_w = inr ? mem_m[a[8:0]] : 32'h0;
      new_w = old_w;
      for (int i = 0; i < 4; i++) if (w[i]) new_w[i*8 +: 8] = d[i*8 +: 8];
      if (inr) mem_m[a[8:0]] = new_w;
      for (int k = 0; k < NC; k++) begin
        x.cyc = cyc + 1 + ((k >= 3) ? 1 : 0);
        case (k % 3)
          0: begin x.d = old_w; sbq[k].push_back(x); end
          1: begin x.d = inr ? new_w : 32'h0; sbq[k].push_back(x); end
          default: if (w == 4'h0) begin x.d = old_w; sbq[k].push_back(x); end
        endcase
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) access(1'b0, 4'h0, '0, 32'h0);
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1; en = 1'b0; we = 4'h0;
    tick();
    mon_on = 1'b1;
    for (int k = 0; k < NC; k++) last_do[k] = 32'h0;
    for (int i = 0; i < SIZE; i++) mem_m[i] = 32'h0;
    repeat (hold - 1) tick();
    rst = 1'b0;
  endtask

  task automatic measure_clear(input string name);
    int n;
    n = 0;
    while (busy_w[0] && n < 2000) begin
      access(1'($urandom_range(0, 1)), 4'hF, 10'd300, $urandom);
      n++;
    end
    chk(name, 0, n, SIZE);
  endtask

  initial begin
    logic [3:0]    w;
    logic [AW-1:0] a;

    do_reset(2);
    measure_clear("clear_len");
    access(1'b1, 4'h0, 10'd0, 32'h0);
    access(1'b1, 4'h0, 10'd511, 32'h0);
    idle(3);

    access(1'b1, 4'hF, 10'd5, 32'hAABBCCDD);
    access(1'b1, 4'b0101, 10'd5, 32'h11223344);
    access(1'b1, 4'h0, 10'd5, 32'h0);
    idle(2);
    access(1'b1, 4'hF, 10'd7, 32'h12345678);
    access(1'b1, 4'h0, 10'd7, 32'h0);
    access(1'b1, 4'hF, 10'd5, 32'hDEADBEEF);
    idle(1);
    access(1'b1, 4'h0, 10'd5, 32'h0);
    access(1'b0, 4'hF, 10'd5, 32'h55555555);
    access(1'b1, 4'h0, 10'd5, 32'h0);
    access(1'b1, 4'hF, 10'd600, 32'hFFFFFFFF);
    access(1'b1, 4'h0, 10'd600, 32'h0);
    access(1'b1, 4'h0, 10'd88, 32'h0);
    access(1'b1, 4'hF, 10'd300, 32'hCAFEF00D);
    access(1'b1, 4'h0, 10'd300, 32'h0);
    idle(3);

    do_reset(1);
    repeat (100) access(1'($urandom_range(0, 1)), 4'hF, 10'd300, $urandom);
    do_reset(2);
    measure_clear("clear_len_restart");
    access(1'b1, 4'h0, 10'd300, 32'h0);
    idle(3);

    for (int c = 0; c < 10000; c++) begin
      if (c == 5000) begin
        idle(3);
        do_reset(1);
      end
      w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 9) < 7) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 1023));
      access(1'($urandom_range(0, 3) != 0), w, a, $urandom);
    end
    idle(4);
    for (int k = 0; k < NC; k++) chk("sb_empty", k, sbq[k].size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
